// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter and sequencer for the single-port data memory.
// Optional address range checking: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 6,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_CPU = 2'd1,
    G_DMA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_wait;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_cpu_el;
  logic              w_dma_el;
  logic              w_starve;
  logic              w_cpu_win;
  logic              w_dma_win;
  logic              w_sel_we;
  logic              w_sel_oor;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_ok;
  logic [DATA_W-1:0] w_rd;

  // The requester granted this cycle sits out the next arbitration.
  assign w_cpu_el  = cpu_req && (r_state != G_CPU);
  assign w_dma_el  = dma_req && (r_state != G_DMA);
  assign w_starve  = (r_wait >= MAXW);
  assign w_cpu_win = w_cpu_el && (!w_dma_el || !w_starve);
  assign w_dma_win = w_dma_el && (!w_cpu_el || w_starve);

  assign w_sel_we    = w_dma_win ? dma_we    : cpu_we;
  assign w_sel_addr  = w_dma_win ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_dma_win ? dma_wdata : cpu_wdata;
  assign w_sel_oor   = RC_EN && (|w_sel_addr[ADDR_W-1:MEM_AW+2]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait  <= 4'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_cpu_win || w_dma_win) begin
        r_we    <= w_sel_we;
        r_err   <= w_sel_oor;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (w_dma_win) begin
        r_wait <= 4'd0;
      end else if (w_cpu_win && dma_req && (r_wait < MAXW)) begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

  always_comb begin
    w_next = IDLE;
    unique case (1'b1)
      w_cpu_win: w_next = G_CPU;
      w_dma_win: w_next = G_DMA;
      default:   w_next = IDLE;
    endcase
  end

  // Reset low during a grant drops the access: no write, no ack.
  always_comb begin
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_err   = 1'b0;
    dma_err   = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    w_ok      = (r_state != IDLE) && rst_n && !r_err;
    mem_we    = w_ok && r_we;
    mem_re    = w_ok && !r_we;
    w_rd      = mem_re ? mem_rdata : '0;
    unique case (r_state)
      G_CPU: begin
        cpu_ack   = rst_n;
        cpu_err   = rst_n && r_err;
        cpu_rdata = w_rd;
      end
      G_DMA: begin
        dma_ack   = rst_n;
        dma_err   = rst_n && r_err;
        dma_rdata = w_rd;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a reference model.
// Range-check cases run when DMEM_ARB_RANGE_CHECK_EN is defined.
module tb_dmem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAW = 6;
  localparam int MW  = 4;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack, dma_err;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] f_init(input int i);
    return 32'hC0DE0000 | DW'(i);
  endfunction

  // Data memory stand-in: async read, write on the clock edge.
  logic [DW-1:0] tmem [64];
  bit t_first = 1'b1;
  assign mem_rdata = tmem[mem_addr[MAW+1:2]];
  always @(posedge clk) begin
    if (t_first) begin
      for (int i = 0; i < 64; i++) tmem[i] <= f_init(i);
      t_first <= 1'b0;
    end else if (mem_we) begin
      tmem[mem_addr[MAW+1:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Reference model: who owns each cycle, and what memory holds.
  logic [DW-1:0] rmem [64];
  bit            m_first = 1'b1;
  int            m_last, m_wait, win;
  logic          m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            pend;
  int            pidx;
  logic [DW-1:0] pdat;
  bit            ce, de;

  always @(posedge clk) begin : model
    exp_t e;
    if (m_first) begin
      for (int i = 0; i < 64; i++) rmem[i] = f_init(i);
      m_first = 1'b0;
    end
    if (pend && rst_n) rmem[pidx] = pdat;
    pend = 1'b0;
    win  = 0;
    if (!rst_n) begin
      m_last = 0; m_wait = 0; m_we = 1'b0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0;
    end else begin
      ce = cpu_req && (m_last != 1);
      de = dma_req && (m_last != 2);
      if (ce && de) win = (m_wait == MW) ? 2 : 1;
      else if (ce) win = 1;
      else if (de) win = 2;
      if (win == 1) begin
        m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
        if (dma_req && m_wait < MW) m_wait++;
      end else if (win == 2) begin
        m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
        m_wait = 0;
      end
      if (win != 0) begin
        m_err = RC && ((m_addr >> (MAW + 2)) != 0);
        if (m_we && !m_err) begin
          pend = 1'b1;
          pidx = int'(m_addr[MAW+1:2]);
          pdat = m_wdata;
        end
      end
      m_last = win;
    end
    e.port  = win;
    e.we    = m_we;
    e.err   = m_err;
    e.addr  = m_addr;
    e.wdata = m_wdata;
    e.rdata = (win != 0 && !m_we && !m_err) ?
              rmem[int'(m_addr[MAW+1:2])] : '0;
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic ca, da, xwe, xre;
    logic [DW-1:0] cr, dr;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      ca  = (e.port == 1) && rst_n;
      da  = (e.port == 2) && rst_n;
      xwe = (e.port != 0) && e.we && !e.err && rst_n;
      xre = (e.port != 0) && !e.we && !e.err && rst_n;
      cr  = (ca && xre) ? e.rdata : '0;
      dr  = (da && xre) ? e.rdata : '0;
      chk("ack_err_busy", {cpu_ack, dma_ack, cpu_err, dma_err, busy},
          {ca, da, ca && e.err, da && e.err, e.port != 0});
      chk("mem_port", {mem_we, mem_re, mem_addr, mem_wdata},
          {xwe, xre, e.addr, e.wdata});
      chk("rdata", {cpu_rdata, dma_rdata}, {cr, dr});
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
    return a;
  endfunction

  task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output logic er,
                            output logic mw, output logic [AW-1:0] ma);
    bit got;
    rd = '0; er = 1'b0; mw = 1'b0; ma = '0; got = 1'b0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        rd = cpu_rdata; er = cpu_err; mw = mem_we; ma = mem_addr;
        got = 1'b1;
        break;
      end
    end
    chk("cpu_access_ack", 128'(got), 128'(1));
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic drive_cpu(input int n);
    int gap;
    bit got;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        cpu_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rnd_addr();
      cpu_wdata = $urandom;
      cpu_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (cpu_ack) begin got = 1'b1; break; end
      end
      chk("cpu_wait_bound", 128'(got), 128'(1));
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
  endtask

  // DMA must be served within the starvation bound.
  task automatic drive_dma(input int n);
    int gap;
    bit got;
    for (int k = 0; k < n; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (gap != 0) begin
        dma_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      dma_we = 1'($urandom_range(0, 1));
      dma_addr = rnd_addr();
      dma_wdata = $urandom;
      dma_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 2 * MW + 1; c++) begin
        @(negedge clk);
        if (dma_ack) begin got = 1'b1; break; end
      end
      chk("dma_wait_bound", 128'(got), 128'(1));
      @(posedge clk);
      #1;
    end
    dma_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          er, mw;
    logic [AW-1:0] ma;
    int            n;
    bit            got;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4; dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk("first_cpu_ack_cycle", 128'(n), 128'(2));
    repeat (8) @(posedge clk);
    #1 cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cpu_access(1'b1, 32'h0C, 32'hDEADBEEF, rd, er, mw, ma);
    chk("wr_mem_we", 128'(mw), 128'(1));
    chk("wr_mem_addr", 128'(ma), 128'(32'h0C));
    cpu_access(1'b0, 32'h0C, '0, rd, er, mw, ma);
    chk("rd_0c", 128'(rd), 128'(32'hDEADBEEF));

    cpu_access(1'b1, 32'h10, 32'hA5A5A5A5, rd, er, mw, ma);
    dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'h12345678;
    dma_req = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_addr", 128'(mem_addr), 128'(32'h10));
    chk("rst_mid_mem_we", 128'(mem_we), 128'(0));
    chk("rst_mid_dma_ack", 128'(dma_ack), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cpu_access(1'b0, 32'h10, '0, rd, er, mw, ma);
    chk("rd_after_rst", 128'(rd), 128'(32'hA5A5A5A5));

`ifdef DMEM_ARB_RANGE_CHECK_EN
    cpu_access(1'b1, 32'h400, 32'h11111111, rd, er, mw, ma);
    chk("oor_wr_err", 128'(er), 128'(1));
    chk("oor_wr_we", 128'(mw), 128'(0));
    cpu_access(1'b0, 32'h400, '0, rd, er, mw, ma);
    chk("oor_rd_data", 128'(rd), 128'(0));
    chk("oor_rd_err", 128'(er), 128'(1));
`endif

    fork
      drive_cpu(150);
      drive_dma(150);
    join
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
